// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the fetch stage: PC width,
//            jump-LUT pointer width, run-control state encoding and the PC
//            value loaded on reset and on every start.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int PC_W      = 10;
    localparam int LUT_PTR_W = 4;

    // PC value after reset and at the start of every run.
    localparam logic [PC_W-1:0] C_PC_RESET = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/jump_lut.sv
`default_nettype none
// ============================================================================
// Module   : jump_lut
// Purpose  : DEPTH x DATA_W register array holding jump targets / offsets.
//            One synchronous write port, one combinational read port,
//            asynchronous clear of every entry.
// Ports    : clk        - clock
//            rst        - asynchronous active-high clear
//            i_wr_en    - write strobe (already qualified by the caller)
//            i_wr_addr  - write index
//            i_wr_data  - write value
//            i_rd_addr  - read index
//            o_rd_data  - entry at i_rd_addr
// Revision : 1.0 - initial release
// ============================================================================
module jump_lut
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::PC_W,
    parameter int ADDR_W = cpu_pkg::LUT_PTR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem_q[i_rd_addr];

endmodule : jump_lut
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Program counter and branch-target stage. Holds the PC, the
//            16-entry jump-target LUT and the IDLE/RUN/DONE run-control FSM.
//            In RUN the PC increments or is redirected (absolute or signed
//            relative) through the LUT entry selected by lut_ptr.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            start               - begin execution at PC 0 (IDLE/DONE only)
//            halt                - stop execution (RUN only)
//            jmp_en, jmp_abs     - jump strobe and absolute/relative select
//            lut_ptr             - LUT index for jumps
//            lut_wr_en/addr/data - LUT write port (IDLE/DONE only)
//            prog_ctr            - current PC (instruction ROM address)
//            running, done       - registered state decodes
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W      = cpu_pkg::PC_W,
    parameter int LUT_DEPTH = 2 ** cpu_pkg::LUT_PTR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 jmp_en,
    input  logic                 jmp_abs,
    input  logic [LUT_PTR_W-1:0] lut_ptr,
    input  logic                 lut_wr_en,
    input  logic [LUT_PTR_W-1:0] lut_wr_addr,
    input  logic [PC_W-1:0]      lut_wr_data,
    output logic [PC_W-1:0]      prog_ctr,
    output logic                 running,
    output logic                 done
);

    localparam logic [PC_W-1:0] C_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t      r_state_q;
    logic              r_running_q;
    logic              r_done_q;
    logic [PC_W-1:0]   r_pc_q;
    logic [PC_W-1:0]   w_pc_d;
    logic [PC_W-1:0]   w_lut_rd_data;
    logic              w_lut_wr_en;

    // Writes only outside RUN, so a read in RUN never races a write.
    assign w_lut_wr_en = lut_wr_en && (r_state_q != RUN);

    jump_lut #(
        .DATA_W (PC_W),
        .ADDR_W (LUT_PTR_W),
        .DEPTH  (LUT_DEPTH)
    ) u_jump_lut (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_lut_wr_en),
        .i_wr_addr (lut_wr_addr),
        .i_wr_data (lut_wr_data),
        .i_rd_addr (lut_ptr),
        .o_rd_data (w_lut_rd_data)
    );

    // Next PC. The relative add is a plain PC_W-bit sum: a two's-complement
    // offset wraps modulo 2**PC_W exactly like a signed add would.
    always_comb begin
        w_pc_d = r_pc_q;
        if (r_state_q == RUN) begin
            if (!halt) begin
                if (jmp_en) begin
                    w_pc_d = jmp_abs ? w_lut_rd_data : (r_pc_q + w_lut_rd_data);
                end else begin
                    w_pc_d = r_pc_q + C_PC_ONE;
                end
            end
        end else if (start) begin
            w_pc_d = PC_W'(C_PC_RESET);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_q <= PC_W'(C_PC_RESET);
        end else begin
            r_pc_q <= w_pc_d;
        end
    end

    // Run-control FSM with registered running/done decodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q   <= IDLE;
            r_running_q <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            case (r_state_q)
                IDLE, DONE: begin
                    if (start) begin
                        r_state_q   <= RUN;
                        r_running_q <= 1'b1;
                        r_done_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        r_state_q   <= DONE;
                        r_running_q <= 1'b0;
                        r_done_q    <= 1'b1;
                    end
                end
                default: begin
                    r_state_q   <= IDLE;
                    r_running_q <= 1'b0;
                    r_done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign prog_ctr = r_pc_q;
    assign running  = r_running_q;
    assign done     = r_done_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W = 10;

    logic            clk;
    logic            reset;
    logic            start;
    logic            halt;
    logic            jmp_en;
    logic            jmp_abs;
    logic [3:0]      lut_ptr;
    logic            lut_wr_en;
    logic [3:0]      lut_wr_addr;
    logic [PC_W-1:0] lut_wr_data;
    logic [PC_W-1:0] prog_ctr;
    logic            running;
    logic            done;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.PC_W(PC_W), .LUT_DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .jmp_en      (jmp_en),
        .jmp_abs     (jmp_abs),
        .lut_ptr     (lut_ptr),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .prog_ctr    (prog_ctr),
        .running     (running),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input logic [3:0] addr, input logic [PC_W-1:0] data);
        lut_wr_en   = 1'b1;
        lut_wr_addr = addr;
        lut_wr_data = data;
        tick();
        lut_wr_en   = 1'b0;
    endtask

    task automatic jump(input logic abs, input logic [3:0] ptr);
        jmp_en  = 1'b1;
        jmp_abs = abs;
        lut_ptr = ptr;
        tick();
        jmp_en  = 1'b0;
        jmp_abs = 1'b0;
        lut_ptr = 4'd0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        halt        = 1'b0;
        jmp_en      = 1'b0;
        jmp_abs     = 1'b0;
        lut_ptr     = 4'd0;
        lut_wr_en   = 1'b0;
        lut_wr_addr = 4'd0;
        lut_wr_data = '0;

        #12;
        check("reset_pc", 32'(prog_ctr), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Load LUT in IDLE.
        lut_write(4'd5, 10'h040);
        lut_write(4'd2, 10'h3FC);
        lut_write(4'd3, 10'h00A);
        lut_write(4'd9, 10'h3FF);
        lut_write(4'd7, 10'h001);
        lut_write(4'd4, 10'h007);
        lut_write(4'd6, 10'h015);
        check("idle_pc_hold", 32'(prog_ctr), 32'h0);
        check("idle_running", 32'(running), 32'h0);

        // Start and sequential advance.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_running", 32'(running), 32'h1);
        check("start_done", 32'(done), 32'h0);
        check("start_pc", 32'(prog_ctr), 32'h0);
        tick(); check("seq_pc1", 32'(prog_ctr), 32'h1);
        tick(); check("seq_pc2", 32'(prog_ctr), 32'h2);
        tick(); check("seq_pc3", 32'(prog_ctr), 32'h3);

        // Absolute jump then increment.
        jump(1'b1, 4'd5); check("abs_jump", 32'(prog_ctr), 32'h040);
        tick();           check("abs_then_inc", 32'(prog_ctr), 32'h041);

        // Relative -4 from 10.
        jump(1'b1, 4'd3); check("abs_to_10", 32'(prog_ctr), 32'h00A);
        jump(1'b0, 4'd2); check("rel_minus4", 32'(prog_ctr), 32'h006);

        // Relative +1 wrap and increment wrap.
        jump(1'b1, 4'd9); check("abs_to_3ff", 32'(prog_ctr), 32'h3FF);
        jump(1'b0, 4'd7); check("rel_wrap", 32'(prog_ctr), 32'h000);
        jump(1'b1, 4'd9); check("abs_to_3ff_b", 32'(prog_ctr), 32'h3FF);
        tick();           check("inc_wrap", 32'(prog_ctr), 32'h000);

        // LUT write attempted in RUN must be dropped.
        lut_write(4'd0, 10'h123);
        check("run_wr_pc", 32'(prog_ctr), 32'h001);

        // Halt with a simultaneous jump: halt wins, PC holds.
        jump(1'b1, 4'd4); check("abs_to_7", 32'(prog_ctr), 32'h007);
        halt    = 1'b1;
        jmp_en  = 1'b1;
        jmp_abs = 1'b1;
        lut_ptr = 4'd5;
        tick();
        check("halt_done", 32'(done), 32'h1);
        check("halt_running", 32'(running), 32'h0);
        check("halt_pc", 32'(prog_ctr), 32'h007);
        tick();
        halt = 1'b0;
        tick();
        check("done_jmp_ignored", 32'(prog_ctr), 32'h007);
        check("done_stays", 32'(done), 32'h1);
        jmp_en  = 1'b0;
        jmp_abs = 1'b0;
        lut_ptr = 4'd0;

        // Restart from DONE; the dropped write leaves lut[0] at zero.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_pc", 32'(prog_ctr), 32'h0);
        check("restart_running", 32'(running), 32'h1);
        check("restart_done", 32'(done), 32'h0);
        tick();           check("restart_inc", 32'(prog_ctr), 32'h1);
        jump(1'b1, 4'd0); check("dropped_write", 32'(prog_ctr), 32'h000);

        // Asynchronous reset mid-run, between clock edges.
        jump(1'b1, 4'd6); check("abs_to_15", 32'(prog_ctr), 32'h015);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_pc", 32'(prog_ctr), 32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Start together with a LUT write: both take effect.
        start       = 1'b1;
        lut_wr_en   = 1'b1;
        lut_wr_addr = 4'd8;
        lut_wr_data = 10'h0AB;
        tick();
        start     = 1'b0;
        lut_wr_en = 1'b0;
        check("post_rst_start", 32'(running), 32'h1);
        tick(); tick();   check("post_rst_pc2", 32'(prog_ctr), 32'h2);
        jump(1'b1, 4'd5); check("lut5_cleared", 32'(prog_ctr), 32'h000);
        tick();           check("post_rst_inc", 32'(prog_ctr), 32'h1);
        jump(1'b0, 4'd2); check("lut2_cleared", 32'(prog_ctr), 32'h1);
        jump(1'b1, 4'd8); check("start_wr_both", 32'(prog_ctr), 32'h0AB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
